ndpqs_dequeue: RTL

Egress side of the NDP queue system. Tracks per-queue occupancy from the enqueue side's write pulses, picks a non-empty queue by quantum round-robin, and issues one-word read requests to the shared queue storage. Returned words go through a 2-entry credit buffer onto a single valid/ready output port. It sits between queue storage and the egress pipeline stage.

---
 rtl/ndpqs_pkg.sv | 18 +
 rtl/ndpqs_dequeue_if.sv | 29 ++
 rtl/ndpqs_credit_buf.sv | 46 ++++
 rtl/ndpqs_dequeue.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/ndpqs_pkg.sv
// Shared definitions for the NDP queue system egress side.
package ndpqs_pkg;

   localparam int unsigned DATA_WIDTH  = 480;
   localparam int unsigned CTRL_WIDTH  = 32;
   localparam int unsigned NUM_QUEUES  = 8;
   localparam int unsigned DEPTH_WIDTH = 12;
   localparam int unsigned QUANTUM     = 4;
   localparam int unsigned QID_WIDTH   = $clog2(NUM_QUEUES);

   typedef enum logic [0:0] {
      ST_IDLE,
      ST_SERVE
   } state_e;

   typedef logic [QID_WIDTH-1:0] qid_t;

endpackage

// File: rtl/ndpqs_dequeue_if.sv
// Storage read port plus egress valid/ready stream of the dequeue block.
interface ndpqs_dequeue_if #(
   parameter int unsigned DW = ndpqs_pkg::DATA_WIDTH,
   parameter int unsigned CW = ndpqs_pkg::CTRL_WIDTH,
   parameter int unsigned QW = ndpqs_pkg::QID_WIDTH
);

   logic          rd_en;
   logic [QW-1:0] rd_qid;
   logic [CW-1:0] rd_ctl;
   logic [DW-1:0] rd_data;
   logic          out_valid;
   logic          out_ready;
   logic [CW-1:0] out_ctl;
   logic [DW-1:0] out_data;

   // Dequeue block side
   modport master (
      output rd_en, rd_qid, out_valid, out_ctl, out_data,
      input  rd_ctl, rd_data, out_ready
   );

   // Storage / downstream side
   modport slave (
      input  rd_en, rd_qid, out_valid, out_ctl, out_data,
      output rd_ctl, rd_data, out_ready
   );

endinterface

// File: rtl/ndpqs_credit_buf.sv
// Two-entry FIFO absorbing words returned from queue storage.
module ndpqs_credit_buf #(
   parameter int unsigned W = 512
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic [W-1:0] push_word_i,
   input  logic         pop_i,
   output logic [W-1:0] head_o,
   output logic         valid_o,
   output logic [1:0]   occ_o
);

   logic [W-1:0] mem_q [2];
   logic         wr_ptr_q;
   logic         rd_ptr_q;
   logic [1:0]   occ_q;
   logic         pop;

   assign valid_o = (occ_q != 2'd0);
   assign pop     = pop_i && valid_o;
   assign head_o  = mem_q[rd_ptr_q];
   assign occ_o   = occ_q;

   // Storage, pointers and occupancy; reset clears entries so the head reads zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         occ_q    <= 2'd0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_word_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         occ_q <= occ_q + {1'b0, push_i} - {1'b0, pop};
      end
   end

endmodule

// File: rtl/ndpqs_dequeue.sv
// Egress side of the NDP queue system: depth tracking, quantum round-robin
// arbitration, one-word storage reads and a credit-limited return buffer.
module ndpqs_dequeue
   import ndpqs_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = ndpqs_pkg::DATA_WIDTH,
   parameter int unsigned CTRL_WIDTH  = ndpqs_pkg::CTRL_WIDTH,
   parameter int unsigned NUM_QUEUES  = ndpqs_pkg::NUM_QUEUES,
   parameter int unsigned DEPTH_WIDTH = ndpqs_pkg::DEPTH_WIDTH,
   parameter int unsigned QUANTUM     = ndpqs_pkg::QUANTUM
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_QUEUES-1:0]             enq_pulse_i,
   ndpqs_dequeue_if.master                   bus,
   output logic [NUM_QUEUES*DEPTH_WIDTH-1:0] q_depth_o,
   output logic [NUM_QUEUES-1:0]             ovf_err_o
);

   localparam int unsigned QW = $clog2(NUM_QUEUES);
   localparam int unsigned BW = $clog2(QUANTUM + 1);
   localparam int unsigned WW = CTRL_WIDTH + DATA_WIDTH;

   logic [DEPTH_WIDTH-1:0] depth_q [NUM_QUEUES];
   logic [DEPTH_WIDTH-1:0] depth_d [NUM_QUEUES];
   logic [NUM_QUEUES-1:0]  ovf_q;
   logic [NUM_QUEUES-1:0]  ovf_d;
   state_e                 state_q;
   logic [QW-1:0]          sel_q;
   logic [QW-1:0]          rr_q;
   logic [BW-1:0]          burst_q;
   logic                   inflight_q;

   logic [1:0]             occ;
   logic                   out_valid;
   logic [WW-1:0]          head;
   logic                   pop;
   logic                   credit_ok;
   logic                   cur_nz;
   logic                   rd_fire;
   logic                   last_word;
   logic                   drain;
   logic                   found;
   logic [QW-1:0]          pick;
   logic [QW-1:0]          nxt_q;

   assign pop       = out_valid && bus.out_ready;
   // free = 2 - occ - inflight + pop > 0, rearranged to avoid negatives
   assign credit_ok = ({1'b0, occ} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop});
   assign cur_nz    = (depth_q[sel_q] != '0);
   assign rd_fire   = (state_q == ST_SERVE) && cur_nz && credit_ok;
   assign last_word = ((burst_q + BW'(1)) == BW'(QUANTUM));
   assign drain     = (depth_q[sel_q] == DEPTH_WIDTH'(1)) && !enq_pulse_i[sel_q];
   assign nxt_q     = QW'((32'(sel_q) + 32'd1) % NUM_QUEUES);

   assign bus.rd_en    = rd_fire;
   assign bus.rd_qid   = sel_q;
   assign bus.out_valid = out_valid;
   assign bus.out_ctl  = head[WW-1 -: CTRL_WIDTH];
   assign bus.out_data = head[DATA_WIDTH-1:0];
   assign ovf_err_o    = ovf_q;

   ndpqs_credit_buf #(
      .W (WW)
   ) u_buf (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (inflight_q),
      .push_word_i ({bus.rd_ctl, bus.rd_data}),
      .pop_i       (bus.out_ready),
      .head_o      (head),
      .valid_o     (out_valid),
      .occ_o       (occ)
   );

   // Next depth per queue: enqueue and read cancel; enqueue at full saturates and flags
   always_comb begin
      ovf_d = ovf_q;
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
         depth_d[i] = depth_q[i];
         if (enq_pulse_i[i] && !(rd_fire && sel_q == QW'(i))) begin
            if (depth_q[i] == '1) begin
               ovf_d[i] = 1'b1;
            end else begin
               depth_d[i] = depth_q[i] + DEPTH_WIDTH'(1);
            end
         end else if (!enq_pulse_i[i] && rd_fire && sel_q == QW'(i)) begin
            depth_d[i] = depth_q[i] - DEPTH_WIDTH'(1);
         end
      end
   end

   // First non-empty queue at or after rr_q, wrapping
   always_comb begin
      int unsigned idx;
      idx   = 0;
      found = 1'b0;
      pick  = rr_q;
      for (int unsigned k = 0; k < NUM_QUEUES; k++) begin
         idx = (32'(rr_q) + k) % NUM_QUEUES;
         if (!found && depth_q[idx] != '0) begin
            found = 1'b1;
            pick  = QW'(idx);
         end
      end
   end

   // Flatten depth counters onto the status port
   always_comb begin
      q_depth_o = '0;
      for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
         q_depth_o[i*DEPTH_WIDTH +: DEPTH_WIDTH] = depth_q[i];
      end
   end

   // Depth counters, sticky overflow flags and return-path in-flight marker
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
            depth_q[i] <= '0;
         end
         ovf_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         for (int unsigned i = 0; i < NUM_QUEUES; i++) begin
            depth_q[i] <= depth_d[i];
         end
         ovf_q      <= ovf_d;
         inflight_q <= rd_fire;
      end
   end

   // Grant FSM: IDLE picks a queue, SERVE reads up to QUANTUM words or until empty
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         rr_q    <= '0;
         burst_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (found) begin
                  sel_q   <= pick;
                  burst_q <= '0;
                  state_q <= ST_SERVE;
               end
            end
            ST_SERVE: begin
               if (rd_fire) begin
                  burst_q <= burst_q + BW'(1);
                  if (last_word || drain) begin
                     rr_q    <= nxt_q;
                     state_q <= ST_IDLE;
                  end
               end else if (!cur_nz) begin
                  rr_q    <= nxt_q;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule
